// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register. Captures the ALU result, store data, rd and the
// MEM/WB control bits, resolves BEQ into a one-cycle redirect pulse with its
// target, and keeps a saturating count of taken branches.
//
// Handshake: ex_ready tells EX that this stage accepts its instruction on the
// next rising edge. It is high when not in reset and either MEM is not stalled
// or a flush is discarding the EX instruction anyway. ex_valid qualifies the
// EX entry; mem_valid qualifies the MEM entry. A held entry (stall) is never
// re-captured, so its side effects, including pc_src, happen once.
module ex_mem_stage #(
  parameter int n  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [n-1:0]  alu_out,
  input  logic          alu_zero,
  input  logic [n-1:0]  rs2_data,
  input  logic [4:0]    rd,
  input  logic [n-1:0]  pc,
  input  logic [n-1:0]  imm,
  input  logic          branch,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic          reg_write,
  input  logic          mem_to_reg,
  input  logic          stall,
  input  logic          flush,
  output logic          ex_ready,
  output logic          mem_valid,
  output logic [n-1:0]  mem_alu_out,
  output logic [n-1:0]  mem_rs2_data,
  output logic [4:0]    mem_rd,
  output logic          mem_mem_read,
  output logic          mem_mem_write,
  output logic          mem_reg_write,
  output logic          mem_mem_to_reg,
  output logic          pc_src,
  output logic [n-1:0]  branch_target,
  output logic [CW-1:0] taken_cnt
);

  logic          valid_q,      valid_d;
  logic [n-1:0]  alu_out_q,    alu_out_d;
  logic [n-1:0]  rs2_data_q,   rs2_data_d;
  logic [4:0]    rd_q,         rd_d;
  logic          mem_read_q,   mem_read_d;
  logic          mem_write_q,  mem_write_d;
  logic          reg_write_q,  reg_write_d;
  logic          mem_to_reg_q, mem_to_reg_d;
  logic          pc_src_q,     pc_src_d;
  logic [n-1:0]  target_q,     target_d;
  logic [CW-1:0] taken_cnt_q,  taken_cnt_d;
  logic          taken;

  // Readiness depends only on reset and the hazard controls, never on data.
  assign ex_ready = ~rst & (~stall | flush);

  // A BEQ is taken when the subtract result is zero on a valid branch.
  assign taken = ex_valid & branch & alu_zero;

  // Next-state selection: flush beats stall beats load; reset is in the flop block.
  always_comb begin
    valid_d      = valid_q;
    alu_out_d    = alu_out_q;
    rs2_data_d   = rs2_data_q;
    rd_d         = rd_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    pc_src_d     = 1'b0;
    target_d     = target_q;
    taken_cnt_d  = taken_cnt_q;
    if (flush) begin
      // Bubble: kill validity and side effects, keep data fields as they are.
      valid_d      = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end else if (!stall) begin
      valid_d      = ex_valid;
      alu_out_d    = alu_out;
      rs2_data_d   = rs2_data;
      rd_d         = rd;
      mem_read_d   = mem_read   & ex_valid;
      mem_write_d  = mem_write  & ex_valid;
      reg_write_d  = reg_write  & ex_valid;
      mem_to_reg_d = mem_to_reg & ex_valid;
      pc_src_d     = taken;
      if (taken) begin
        target_d = pc + imm;
        if (taken_cnt_q != {CW{1'b1}}) begin
          taken_cnt_d = taken_cnt_q + 1'b1;
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      alu_out_q    <= '0;
      rs2_data_q   <= '0;
      rd_q         <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      pc_src_q     <= 1'b0;
      target_q     <= '0;
      taken_cnt_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      alu_out_q    <= alu_out_d;
      rs2_data_q   <= rs2_data_d;
      rd_q         <= rd_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      pc_src_q     <= pc_src_d;
      target_q     <= target_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_alu_out    = alu_out_q;
  assign mem_rs2_data   = rs2_data_q;
  assign mem_rd         = rd_q;
  assign mem_mem_read   = mem_read_q;
  assign mem_mem_write  = mem_write_q;
  assign mem_reg_write  = reg_write_q;
  assign mem_mem_to_reg = mem_to_reg_q;
  assign pc_src         = pc_src_q;
  assign branch_target  = target_q;
  assign taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed vector table, hand-written
// multi-cycle sequences and randomized cycles against a reference model.
module tb_ex_mem_stage;
  localparam int N  = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst, ex_valid, alu_zero, branch;
  logic          mem_read, mem_write, reg_write, mem_to_reg, stall, flush;
  logic [N-1:0]  alu_out, rs2_data, pc, imm;
  logic [4:0]    rd;
  logic          ex_ready, mem_valid, mem_mem_read, mem_mem_write;
  logic          mem_reg_write, mem_mem_to_reg, pc_src;
  logic [N-1:0]  mem_alu_out, mem_rs2_data, branch_target;
  logic [4:0]    mem_rd;
  logic [CW-1:0] taken_cnt;

  always #5 clk = ~clk;

  ex_mem_stage #(.n(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_out(alu_out),
    .alu_zero(alu_zero), .rs2_data(rs2_data), .rd(rd), .pc(pc), .imm(imm),
    .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .stall(stall),
    .flush(flush), .ex_ready(ex_ready), .mem_valid(mem_valid),
    .mem_alu_out(mem_alu_out), .mem_rs2_data(mem_rs2_data), .mem_rd(mem_rd),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
    .pc_src(pc_src), .branch_target(branch_target), .taken_cnt(taken_cnt)
  );

  // ---------------- stimulus records ----------------
  typedef struct {
    logic        rst;
    logic        ex_valid;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        stall;
    logic        flush;
  } in_t;

  typedef struct {
    in_t         i;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_alu;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic        e_mw;
    logic        e_pc_src;
    logic [31:0] e_tgt;
    int          e_cnt;
  } vec_t;

  // ---------------- reference model (MEM-stage entry as a record) ----------------
  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        mr, mw, rw, m2r;
    logic        redirect;
    logic [31:0] target;
    int          taken_total;
  } model_t;

  model_t m;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // What the MEM stage should hold after one edge with inputs x.
  function automatic model_t model_next(model_t s, in_t x);
    model_t r = s;
    logic [63:0] sum;
    bit is_taken;
    r.redirect = 1'b0;
    if (x.rst) begin
      r = '{default: '0};
      r.taken_total = 0;
    end else if (x.flush) begin
      r.valid = 0; r.mr = 0; r.mw = 0; r.rw = 0; r.m2r = 0;
    end else if (!x.stall) begin
      is_taken = x.ex_valid && x.branch && x.alu_zero;
      r.valid = x.ex_valid;
      r.alu = x.alu_out; r.rs2 = x.rs2_data; r.rd = x.rd;
      r.mr  = x.ex_valid ? x.mem_read   : 1'b0;
      r.mw  = x.ex_valid ? x.mem_write  : 1'b0;
      r.rw  = x.ex_valid ? x.reg_write  : 1'b0;
      r.m2r = x.ex_valid ? x.mem_to_reg : 1'b0;
      r.redirect = is_taken;
      if (is_taken) begin
        sum = {32'd0, x.pc} + {32'd0, x.imm};
        r.target = sum[31:0];
        r.taken_total = (s.taken_total + 1 > CNT_MAX) ? CNT_MAX : s.taken_total + 1;
      end
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input in_t x);
    rst = x.rst; ex_valid = x.ex_valid; alu_out = x.alu_out; alu_zero = x.alu_zero;
    rs2_data = x.rs2_data; rd = x.rd; pc = x.pc; imm = x.imm; branch = x.branch;
    mem_read = x.mem_read; mem_write = x.mem_write; reg_write = x.reg_write;
    mem_to_reg = x.mem_to_reg; stall = x.stall; flush = x.flush;
  endtask

  // Apply one cycle: check ex_ready before the edge, then every output after it.
  task automatic cycle(input in_t x);
    drive(x);
    #1;
    chk("ex_ready", {31'd0, ex_ready}, {31'd0, (!x.rst && (!x.stall || x.flush))});
    @(posedge clk);
    m = model_next(m, x);
    #1;
    chk("mem_valid",      {31'd0, mem_valid},      {31'd0, m.valid});
    chk("mem_alu_out",    mem_alu_out,             m.alu);
    chk("mem_rs2_data",   mem_rs2_data,            m.rs2);
    chk("mem_rd",         {27'd0, mem_rd},         {27'd0, m.rd});
    chk("mem_mem_read",   {31'd0, mem_mem_read},   {31'd0, m.mr});
    chk("mem_mem_write",  {31'd0, mem_mem_write},  {31'd0, m.mw});
    chk("mem_reg_write",  {31'd0, mem_reg_write},  {31'd0, m.rw});
    chk("mem_mem_to_reg", {31'd0, mem_mem_to_reg}, {31'd0, m.m2r});
    chk("pc_src",         {31'd0, pc_src},         {31'd0, m.redirect});
    chk("branch_target",  branch_target,           m.target);
    chk("taken_cnt",      {28'd0, taken_cnt},      m.taken_total);
  endtask

  function automatic in_t rand_in();
    in_t x;
    x.rst        = ($urandom_range(0, 49) == 0);
    x.ex_valid   = ($urandom_range(0, 3) != 0);
    x.alu_out    = $urandom;
    x.alu_zero   = $urandom_range(0, 1);
    x.rs2_data   = $urandom;
    x.rd         = 5'($urandom_range(0, 31));
    x.pc         = $urandom;
    x.imm        = $urandom & 32'hFFFF_FFFE;
    x.branch     = $urandom_range(0, 1);
    x.mem_read   = $urandom_range(0, 1);
    x.mem_write  = $urandom_range(0, 1);
    x.reg_write  = $urandom_range(0, 1);
    x.mem_to_reg = $urandom_range(0, 1);
    x.stall      = ($urandom_range(0, 3) == 0);
    x.flush      = ($urandom_range(0, 5) == 0);
    return x;
  endfunction

  function automatic in_t taken_br(input logic [31:0] p, input logic [31:0] off);
    in_t x = '{default: '0};
    x.ex_valid = 1; x.branch = 1; x.alu_zero = 1; x.pc = p; x.imm = off;
    return x;
  endfunction

  // ---------------- test sequence ----------------
  vec_t vecs[5];
  in_t  t;

  initial begin
    m = '{default: '0};
    m.taken_total = 0;

    // Reset with random inputs for two cycles.
    for (int k = 0; k < 2; k++) begin
      t = rand_in();
      t.rst = 1;
      cycle(t);
    end

    // Directed vector table, expectations worked out by hand.
    vecs[0] = '{'{0,1,32'h1234,0,32'h0,5'd5,32'h0,32'h0,0,0,0,1,0,0,0},
                1, 1, 32'h1234, 5'd5, 1, 0, 0, 32'h0, 0};
    vecs[1] = '{'{0,1,32'h0,1,32'h0,5'd0,32'h100,32'hFFFF_FFF0,1,0,0,0,0,0,0},
                1, 1, 32'h0, 5'd0, 0, 0, 1, 32'h0F0, 1};
    vecs[2] = '{'{0,1,32'h0,0,32'h0,5'd0,32'h300,32'h40,1,0,0,0,0,0,0},
                1, 1, 32'h0, 5'd0, 0, 0, 0, 32'h0F0, 1};
    vecs[3] = '{'{0,1,32'hAAAA,0,32'h0,5'd7,32'h0,32'h0,0,0,1,0,0,1,1},
                1, 0, 32'h0, 5'd0, 0, 0, 0, 32'h0F0, 1};
    vecs[4] = '{'{0,0,32'h55,0,32'h0,5'd9,32'h0,32'h0,0,0,1,1,0,0,0},
                1, 0, 32'h55, 5'd9, 0, 0, 0, 32'h0F0, 1};
    for (int v = 0; v < 5; v++) begin
      drive(vecs[v].i);
      #1;
      chk("vec_ex_ready", {31'd0, ex_ready}, {31'd0, vecs[v].e_ready});
      cycle(vecs[v].i);
      chk("vec_mem_valid",  {31'd0, mem_valid},     {31'd0, vecs[v].e_valid});
      chk("vec_alu_out",    mem_alu_out,            vecs[v].e_alu);
      chk("vec_rd",         {27'd0, mem_rd},        {27'd0, vecs[v].e_rd});
      chk("vec_reg_write",  {31'd0, mem_reg_write}, {31'd0, vecs[v].e_rw});
      chk("vec_mem_write",  {31'd0, mem_mem_write}, {31'd0, vecs[v].e_mw});
      chk("vec_pc_src",     {31'd0, pc_src},        {31'd0, vecs[v].e_pc_src});
      chk("vec_target",     branch_target,          vecs[v].e_tgt);
      chk("vec_taken_cnt",  {28'd0, taken_cnt},     vecs[v].e_cnt);
    end

    // Stall after a taken branch: pulse once, then hold for three cycles.
    cycle(taken_br(32'h200, 32'h40));
    chk("stall_seq_pulse", {31'd0, pc_src}, 32'd1);
    chk("stall_seq_tgt", branch_target, 32'h240);
    for (int k = 0; k < 3; k++) begin
      t = rand_in();
      t.rst = 0; t.flush = 0; t.stall = 1;
      cycle(t);
      chk("stall_seq_no_refire", {31'd0, pc_src}, 32'd0);
      chk("stall_seq_hold_tgt", branch_target, 32'h240);
    end

    // Back-to-back taken branches on consecutive loads.
    cycle(taken_br(32'h1000, 32'h8));
    chk("b2b_first_tgt", branch_target, 32'h1008);
    cycle(taken_br(32'h2000, 32'hFFFF_FFFC));
    chk("b2b_second_pulse", {31'd0, pc_src}, 32'd1);
    chk("b2b_second_tgt", branch_target, 32'h1FFC);

    // Reset presented together with a taken branch.
    t = taken_br(32'h400, 32'h10);
    t.rst = 1;
    cycle(t);
    chk("rst_branch_pc_src", {31'd0, pc_src}, 32'd0);

    // Saturation: 17 taken branches with a 4-bit counter.
    for (int k = 0; k < 17; k++) cycle(taken_br(32'h10 * k, 32'h20));
    chk("sat_cnt", {28'd0, taken_cnt}, CNT_MAX);
    t = '{default: '0};
    cycle(t);
    chk("sat_hold", {28'd0, taken_cnt}, CNT_MAX);

    // Randomized cycles against the model.
    for (int k = 0; k < 400; k++) cycle(rand_in());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
